// File: rtl/spmv_pkg.sv
// Shared definitions for the SpMV run sequencer.
//   AW / YW : address widths of the rid/value/xd RAMs and of the y RAM.
//   SEL_*   : ld_sel target codes; any other code is an illegal target.
//   state_t : run-sequencer FSM states.
package spmv_pkg;

  localparam int AW = 4;
  localparam int YW = 3;

  localparam logic [1:0] SEL_RID = 2'd0;
  localparam logic [1:0] SEL_VAL = 2'd1;
  localparam logic [1:0] SEL_XD  = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    DRAIN_RD,
    DRAIN_WAIT,
    DRAIN_OUT,
    DONE
  } state_t;

endpackage

// File: rtl/spmv_run_ctrl.sv
// Run sequencer for the HLS SpMV core and its rid/value/xd/y block RAMs.
// Each command loads the operand RAMs from a host beat stream, starts the
// core with the ap_start/ap_ready handshake, waits for ap_done (bounded by a
// watchdog), then streams the y RAM out with backpressure.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_start/busy/done   command request, busy level, completion pulse
//   err_sel, err_timeout  sticky errors, cleared by the next accepted command
//   ld_*                  host load beat stream (valid/ready, sel/addr/data/last)
//   mem_*                 shared port-A write side of the rid/value/xd RAMs
//   core_owns_mem         port-A mux select (1 = core, 0 = controller)
//   ap_*                  HLS core block-level handshake
//   y_ce/y_addr/y_q       y RAM read port (1-cycle latency)
//   out_*                 result beat stream (valid/ready, data/last)
module spmv_run_ctrl
  import spmv_pkg::*;
#(
  parameter int NNZ     = 16,
  parameter int NROWS   = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_start,
  output logic          cmd_busy,
  output logic          cmd_done,
  output logic          err_sel,
  output logic          err_timeout,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [1:0]    ld_sel,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we_rid,
  output logic          mem_we_val,
  output logic          mem_we_xd,
  output logic          core_owns_mem,
  output logic          ap_start,
  input  logic          ap_ready,
  input  logic          ap_done,
  input  logic          ap_idle,
  output logic          y_ce,
  output logic [YW-1:0] y_addr,
  input  logic [DW-1:0] y_q,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  localparam int            TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0] WD_LAST  = TW'(TIMEOUT - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(NROWS - 1);

  // The package address widths must match the RAM depths of this instance.
  if ($clog2(NNZ) != AW || $clog2(NROWS) != YW) begin : g_depth_mismatch
    $error("spmv_run_ctrl: NNZ/NROWS do not match spmv_pkg AW/YW");
  end

  state_t        state;
  logic [TW-1:0] wd_cnt;
  logic [YW-1:0] row;
  logic          err_sel_q;
  logic          err_timeout_q;
  logic [DW-1:0] y_data_p0;
  logic          ld_fire;
  logic          sel_legal;

  // ap_idle is informational only; no transition depends on it.
  logic unused_ap_idle;
  assign unused_ap_idle = ap_idle;

  assign ld_fire   = (state == LOAD) && ld_valid;
  assign sel_legal = (ld_sel == SEL_RID) || (ld_sel == SEL_VAL) || (ld_sel == SEL_XD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      wd_cnt        <= '0;
      row           <= '0;
      err_sel_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_start) begin
            err_sel_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            state         <= LOAD;
          end
        end
        LOAD: begin
          if (ld_fire) begin
            // An illegal target still counts as a beat, so ld_last ends LOAD.
            if (!sel_legal) err_sel_q <= 1'b1;
            if (ld_last) begin
              wd_cnt <= '0;
              state  <= START;
            end
          end
        end
        START: begin
          if (ap_ready) begin
            row   <= '0;
            state <= ap_done ? DRAIN_RD : RUN;
          end
        end
        RUN: begin
          if (ap_done) begin
            row   <= '0;
            state <= DRAIN_RD;
          end else if (wd_cnt == WD_LAST) begin
            err_timeout_q <= 1'b1;
            state         <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        DRAIN_RD:   state <= DRAIN_WAIT;
        DRAIN_WAIT: state <= DRAIN_OUT;
        DRAIN_OUT: begin
          if (out_ready) begin
            if (row == ROW_LAST) begin
              state <= DONE;
            end else begin
              row   <= row + 1'b1;
              state <= DRAIN_RD;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // y RAM read data lands one cycle after y_ce; hold it for the output beat.
  always_ff @(posedge clk) begin
    if (state == DRAIN_WAIT) y_data_p0 <= y_q;
  end

  assign cmd_busy    = (state != IDLE);
  assign cmd_done    = (state == DONE);
  assign err_sel     = err_sel_q;
  assign err_timeout = err_timeout_q;

  assign ld_ready   = (state == LOAD);
  assign mem_addr   = ld_fire ? ld_addr : '0;
  assign mem_wdata  = ld_fire ? ld_data : '0;
  assign mem_we_rid = ld_fire && (ld_sel == SEL_RID);
  assign mem_we_val = ld_fire && (ld_sel == SEL_VAL);
  assign mem_we_xd  = ld_fire && (ld_sel == SEL_XD);

  assign core_owns_mem = (state == START) || (state == RUN);
  assign ap_start      = (state == START);

  assign y_ce   = (state == DRAIN_RD);
  assign y_addr = y_ce ? row : '0;

  // The data register is not reset; gating keeps the port at 0 when idle.
  assign out_valid = (state == DRAIN_OUT);
  assign out_last  = out_valid && (row == ROW_LAST);
  assign out_data  = out_valid ? y_data_p0 : '0;

endmodule

// File: doc/spmv_run_ctrl.md
Name: spmv_run_ctrl

Overview:
- Run-sequencer for the HLS SpMV core and its rid/value/xd/y block RAMs. Replaces the tied-high ap_start.
- Per command it runs four steps: load the operand RAMs from a host beat stream, start the core with the ap_start/ap_ready handshake, wait for ap_done, then stream the y result RAM out with backpressure.
- Sits in the SpMV top between the host-side loader/ILA and the core/BRAM instances. It owns the select for the RAM port-A mux.

Parameters:
- NNZ, 16, depth of rid/value/xd RAMs; AW = clog2(NNZ) = 4.
- NROWS, 8, depth of y RAM; YW = clog2(NROWS) = 3.
- DW, 32, data width of all RAMs and streams.
- TIMEOUT, 4096, maximum number of RUN-state cycles before abort.

Ports:
- clk  in  1  single clock, shared with the core and the BRAMs.
- rst_n  in  1  synchronous, active-low reset.
- cmd_start  in  1  single-cycle run request; sampled only in IDLE.
- cmd_busy  out  1  high in every state except IDLE.
- cmd_done  out  1  one-cycle pulse when a run completes or aborts.
- err_sel  out  1  sticky error: illegal ld_sel seen; cleared by the next accepted cmd_start.
- err_timeout  out  1  sticky error: RUN exceeded TIMEOUT; cleared by the next accepted cmd_start.
- ld_valid  in  1  load beat valid.
- ld_ready  out  1  load beat ready.
- ld_sel  in  2  target RAM: 0 = rid, 1 = value, 2 = xd, 3 = illegal.
- ld_addr  in  AW  write address.
- ld_data  in  DW  write data.
- ld_last  in  1  marks the final load beat.
- mem_addr  out  AW  shared port-A write address.
- mem_wdata  out  DW  shared port-A write data.
- mem_we_rid  out  1  write strobe, rid RAM.
- mem_we_val  out  1  write strobe, value RAM.
- mem_we_xd  out  1  write strobe, xd RAM.
- core_owns_mem  out  1  port-A mux select: 1 = core, 0 = controller.
- ap_start  out  1  core start.
- ap_ready  in  1  core accepted start.
- ap_done  in  1  core finished.
- ap_idle  in  1  core idle; status only.
- y_ce  out  1  y RAM read enable.
- y_addr  out  YW  y RAM read address.
- y_q  in  DW  y RAM read data; 1-cycle read latency.
- out_valid  out  1  result beat valid.
- out_ready  in  1  result beat ready.
- out_data  out  DW  result beat data.
- out_last  out  1  marks the final result beat.

Behaviour:
- Reset, and rst_n low in any state: state = IDLE.
  - All outputs are 0, including ap_start, every mem_we_*, core_owns_mem, y_ce, out_valid, both err flags and cmd_done.
  - An in-flight run is dropped without a cmd_done pulse.
- FSM states: IDLE, LOAD, START, RUN, DRAIN_RD, DRAIN_WAIT, DRAIN_OUT, DONE.
- IDLE:
  - cmd_start = 1 clears both err flags and moves to LOAD.
  - cmd_start in any other state is ignored.
- LOAD:
  - ld_ready = 1 (combinational from state).
  - On each accepted beat (ld_valid & ld_ready), the same cycle drives mem_addr = ld_addr and mem_wdata = ld_data, and pulses the we selected by ld_sel.
  - ld_sel = 3: no we pulses and err_sel is set. The beat still counts, so ld_last on it still ends LOAD.
  - An accepted ld_last moves to START. Addresses are unchecked: NNZ is a power of two, so there is no overflow.
- START:
  - ap_start = 1 and core_owns_mem = 1.
  - ap_start is held until ap_ready = 1 is sampled; it drops the next cycle and the state moves to RUN.
  - If ap_done is also 1 in that same cycle, go straight to DRAIN_RD.
- RUN:
  - core_owns_mem = 1 and the watchdog counter increments each cycle.
  - ap_done = 1: go to DRAIN_RD.
  - Counter reaches TIMEOUT - 1 without ap_done: set err_timeout and go to DONE.
  - Counter width is clog2(TIMEOUT); it is cleared on entry to START.
- DRAIN_RD:
  - core_owns_mem = 0 (core_owns_mem is 0 from DRAIN_RD onward).
  - y_ce = 1 for one cycle with y_addr = row index; the row index starts at 0 when leaving RUN.
  - Next state is DRAIN_WAIT.
- DRAIN_WAIT: capture y_q into the out_data register; go to DRAIN_OUT.
- DRAIN_OUT:
  - out_valid = 1; out_last = 1 when row index = NROWS - 1.
  - out_data stays stable until out_ready = 1.
  - On handshake: if last, go to DONE; otherwise increment the row index and go to DRAIN_RD.
  - Throughput is one beat per 3 cycles minimum.
- DONE: cmd_done = 1 for one cycle, then IDLE.
- Latency, cmd_start to first out_valid, is 1 + load beats + start handshake + core run + 3 cycles.
- ap_idle does not affect any transition.

Decomposition:
- Package spmv_pkg holds:
  - the state enum;
  - localparams AW, YW;
  - ld_sel codes SEL_RID = 0, SEL_VAL = 1, SEL_XD = 2.
- No sub-modules: the watchdog and the row counter stay inline. The port-A mux stays in the SpMV top, driven by core_owns_mem.

Test Plan:
1. Normal run: cmd_start; 16 beats to each of rid, value and xd (ld_last on the 48th beat); core model asserts ap_ready 2 cycles after ap_start and ap_done 20 cycles later; out_ready = 1.
   -> 48 we pulses routed to the correct RAMs; ap_start high exactly until ap_ready; 8 beats equal to the y RAM contents 0..7; out_last on the 8th; one cmd_done pulse; err flags 0.
2. Backpressure: same run with out_ready toggling 1-0-0-1.
   -> out_data is held while out_ready = 0; no row skipped or duplicated; exactly 8 beats.
3. Illegal sel: beat 5 has ld_sel = 3, addr = 2.
   -> no we pulse on that beat; err_sel = 1 and sticky through DONE; it clears on the next cmd_start.
4. Timeout: the core never asserts ap_done.
   -> err_timeout = 1 after 4096 RUN cycles; DONE then IDLE; zero out_valid beats; cmd_done pulses once.
5. Simultaneous ap_ready and ap_done in START.
   -> no RUN cycles; the first y_ce follows the next cycle.
6. Reset mid-run: rst_n = 0 for 1 cycle during DRAIN_OUT row 3.
   -> all outputs 0 the following cycle; state IDLE; no cmd_done; a new cmd_start runs normally.
